cache_ctrl_2way: RTL and testbench

CACHE_CTRL_2WAY -- requirements
Module: cache_ctrl_2way

---
 rtl/cache_ctrl_2way_pkg.sv | 17 +
 rtl/cache_ctrl_2way_if.sv | 41 ++++
 rtl/cache_ctrl_2way_lru_table.sv | 33 +++
 rtl/cache_ctrl_2way.sv | 130 +++++++++++++
 tb/tb_cache_ctrl_2way.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_2way_pkg.sv
// Shared definitions for the 2-way cache controller.
//   state_e  : controller FSM state encoding (2 bits)
//   SETS     : number of sets (4)
//   INDEX_W  : set index width (2)
package cache_ctrl_2way_pkg;

  localparam int unsigned SETS    = 4;
  localparam int unsigned INDEX_W = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWb   = 2'd1,
    StFill = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/cache_ctrl_2way_if.sv
// Request / memory / array-control bundle of the 2-way cache controller.
//   master : requester side (drives request, tag-lookup results and mem_ready)
//   slave  : controller side (drives completion, strobes, way select, lru_q)
// fill_dirty carries the dirty value to store alongside fill_we (the latched
// write flag of the missing request).
interface cache_ctrl_2way_if;
  import cache_ctrl_2way_pkg::*;

  logic               req_valid;
  logic               req_wr;
  logic [INDEX_W-1:0] req_index;
  logic               hit0;
  logic               hit1;
  logic               valid0;
  logic               valid1;
  logic               dirty0;
  logic               dirty1;
  logic               mem_ready;
  logic               req_done;
  logic               stall;
  logic               way_sel;
  logic               mem_rd;
  logic               mem_wr;
  logic               fill_we;
  logic               fill_dirty;
  logic               err;
  logic [SETS-1:0]    lru_q;

  modport master (
    output req_valid, req_wr, req_index, hit0, hit1, valid0, valid1, dirty0, dirty1,
           mem_ready,
    input  req_done, stall, way_sel, mem_rd, mem_wr, fill_we, fill_dirty, err, lru_q
  );

  modport slave (
    input  req_valid, req_wr, req_index, hit0, hit1, valid0, valid1, dirty0, dirty1,
           mem_ready,
    output req_done, stall, way_sel, mem_rd, mem_wr, fill_we, fill_dirty, err, lru_q
  );

endinterface

// File: rtl/cache_ctrl_2way_lru_table.sv
// LRU storage: SETS one-bit entries, bit = way that is the next victim.
//   clk, rst : clock, synchronous active-high reset (clears all entries)
//   we       : write enable
//   addr     : set address, shared by the write port and the read port
//   wdata    : bit written at addr
//   rdata    : combinational read of entry addr
//   entries  : all entries, bit i = set i
module lru_table
  import cache_ctrl_2way_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [INDEX_W-1:0] addr,
  input  logic               wdata,
  output logic               rdata,
  output logic [SETS-1:0]    entries
);

  logic [SETS-1:0] bits_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bits_q <= '0;
    end else if (we) begin
      bits_q[addr] <= wdata;
    end
  end

  assign rdata   = bits_q[addr];
  assign entries = bits_q;

endmodule

// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative cache controller (4 sets). Hits complete in the
// request cycle; misses pick a victim, write it back if dirty, fetch the line
// and complete in a DONE cycle. LRU bit per set marks the next victim.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request, lookup, memory handshake and array-control signals
module cache_ctrl_2way
  import cache_ctrl_2way_pkg::*;
(
  input logic              clk,
  input logic              rst,
  cache_ctrl_2way_if.slave bus
);

  state_e             state_q, state_d;
  logic [INDEX_W-1:0] idx_q, idx_d;
  logic               wr_q, wr_d;
  logic               victim_q, victim_d;

  logic               any_hit;
  logic               hit_way;
  logic               miss_victim;
  logic               victim_dirty;
  logic               lru_rd;
  logic               lru_we;
  logic [INDEX_W-1:0] lru_addr;

  assign any_hit = bus.hit0 | bus.hit1;
  // Way 0 wins when both ways report a hit.
  assign hit_way = ~bus.hit0;

  // Prefer an empty way; only fall back to LRU when both ways are valid.
  assign miss_victim  = !bus.valid0 ? 1'b0 : (!bus.valid1 ? 1'b1 : lru_rd);
  assign victim_dirty = miss_victim ? (bus.valid1 & bus.dirty1) : (bus.valid0 & bus.dirty0);

  // LRU is read only in IDLE (live index) and written on req_done, which is
  // either the IDLE hit cycle (live index) or DONE (latched index).
  assign lru_addr = (state_q == StIdle) ? bus.req_index : idx_q;
  assign lru_we   = bus.req_done;

  lru_table u_lru_table (
    .clk     (clk),
    .rst     (rst),
    .we      (lru_we),
    .addr    (lru_addr),
    .wdata   (~bus.way_sel),
    .rdata   (lru_rd),
    .entries (bus.lru_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    victim_d = victim_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && !any_hit) begin
          idx_d    = bus.req_index;
          wr_d     = bus.req_wr;
          victim_d = miss_victim;
          state_d  = victim_dirty ? StWb : StFill;
        end
      end
      StWb:    if (bus.mem_ready) state_d = StFill;
      StFill:  if (bus.mem_ready) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are forced inactive while rst is high so an abandoned miss can
  // neither fill nor complete in the reset cycle.
  always_comb begin
    bus.req_done   = 1'b0;
    bus.stall      = 1'b0;
    bus.way_sel    = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.fill_we    = 1'b0;
    bus.fill_dirty = 1'b0;
    bus.err        = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            if (any_hit) begin
              bus.req_done = 1'b1;
              bus.way_sel  = hit_way;
              bus.err      = bus.hit0 & bus.hit1;
            end else begin
              bus.stall = 1'b1;
            end
          end
        end
        StWb: begin
          bus.stall   = 1'b1;
          bus.mem_wr  = 1'b1;
          bus.way_sel = victim_q;
        end
        StFill: begin
          bus.stall      = 1'b1;
          bus.mem_rd     = 1'b1;
          bus.way_sel    = victim_q;
          bus.fill_we    = bus.mem_ready;
          bus.fill_dirty = bus.mem_ready & wr_q;
        end
        StDone: begin
          bus.req_done = 1'b1;
          bus.way_sel  = victim_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
module tb_cache_ctrl_2way;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_ctrl_2way_if bus ();

  cache_ctrl_2way dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [3:0] lru_m = 4'b0000;  // reference LRU: bit i = next victim of set i

  task automatic drive_idle_rand();
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'($urandom);
    bus.req_index = 2'($urandom);
    bus.hit0      = 1'($urandom);
    bus.hit1      = 1'($urandom);
    bus.valid0    = 1'($urandom);
    bus.valid1    = 1'($urandom);
    bus.dirty0    = 1'($urandom);
    bus.dirty1    = 1'($urandom);
    bus.mem_ready = 1'($urandom);
  endtask

  // One full request, checked every cycle against the transaction-level
  // model: hit = 1 cycle; miss = request + (wbw+1 if dirty victim) + (fw+1) + done.
  task automatic do_access(input logic [1:0] idx, input logic wr,
                           input logic h0, input logic h1, input logic v0, input logic v1,
                           input logic d0, input logic d1, input int wbw, input int fw);
    logic hit, hway, vic, exp_way, chk_way;
    logic [5:0] exp, obs;
    int wbn, fn, total;
    hit   = h0 | h1;
    hway  = h0 ? 1'b0 : 1'b1;
    vic   = !v0 ? 1'b0 : (!v1 ? 1'b1 : lru_m[idx]);
    wbn   = (!hit && (vic ? (v1 && d1) : (v0 && d0))) ? wbw + 1 : 0;
    fn    = hit ? 0 : fw + 1;
    total = hit ? 1 : 1 + wbn + fn + 1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_index = idx;
        bus.hit0 = h0;  bus.hit1 = h1;
        bus.valid0 = v0; bus.valid1 = v1;
        bus.dirty0 = d0; bus.dirty1 = d1;
        bus.mem_ready = 1'($urandom);
      end else begin
        // Lookup inputs are don't-care after the request cycle.
        drive_idle_rand();
        bus.req_valid = 1'b1;
        if (c <= 1 + wbn) bus.mem_ready = (c == 1 + wbn);
        else if (c <= 1 + wbn + fn) bus.mem_ready = (c == 1 + wbn + fn);
      end
      #1;
      // {req_done, stall, mem_rd, mem_wr, fill_we, err}
      exp = '0; chk_way = 1'b0; exp_way = 1'b0;
      if (hit) begin
        exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, h0 & h1};
        chk_way = 1'b1; exp_way = hway;
      end else if (c == 1) begin
        exp = 6'b010000;
      end else if (c <= 1 + wbn) begin
        exp = 6'b010100; chk_way = 1'b1; exp_way = vic;
      end else if (c <= 1 + wbn + fn) begin
        exp = {4'b0110, (c == 1 + wbn + fn), 1'b0}; chk_way = 1'b1; exp_way = vic;
      end else begin
        exp = 6'b100000; chk_way = 1'b1; exp_way = vic;
      end
      obs = {bus.req_done, bus.stall, bus.mem_rd, bus.mem_wr, bus.fill_we, bus.err};
      n_cmp++;
      if (obs !== exp) begin
        n_bad++;
        $display("FAIL access_outputs idx=%0d cycle=%0d: got %b want %b", idx, c, obs, exp);
      end
      if (chk_way) begin
        n_cmp++;
        if (bus.way_sel !== exp_way) begin
          n_bad++;
          $display("FAIL way_sel idx=%0d cycle=%0d: got %b want %b", idx, c, bus.way_sel,
                   exp_way);
        end
      end
      if (exp[1]) begin
        n_cmp++;
        if (bus.fill_dirty !== wr) begin
          n_bad++;
          $display("FAIL fill_dirty idx=%0d: got %b want %b", idx, bus.fill_dirty, wr);
        end
      end
    end
    lru_m[idx] = hit ? ~hway : ~vic;
    @(negedge clk);
    drive_idle_rand();
    #1;
    obs = {bus.req_done, bus.stall, bus.mem_rd, bus.mem_wr, bus.fill_we, bus.err};
    n_cmp++;
    if (obs !== 6'b0 || bus.way_sel !== 1'b0 || bus.fill_dirty !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_outputs after idx=%0d: got %b/%b want 000000/0", idx, obs,
               bus.way_sel);
    end
    n_cmp++;
    if (bus.lru_q !== lru_m) begin
      n_bad++;
      $display("FAIL lru_q after idx=%0d: got %b want %b", idx, bus.lru_q, lru_m);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_idle_rand();
      rst = 1'b1; bus.req_valid = 1'b1; bus.hit0 = 1'b1; bus.mem_ready = 1'b1;
      #1;
      n_cmp++;
      if ({bus.req_done, bus.stall, bus.mem_rd, bus.mem_wr, bus.fill_we, bus.err} !== 6'b0) begin
        n_bad++;
        $display("FAIL reset_outputs_during_rst: got req_done=%b err=%b", bus.req_done,
                 bus.err);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    drive_idle_rand();
    lru_m = 4'b0000;
    #1;
    n_cmp++;
    if (bus.lru_q !== 4'b0000 || bus.stall !== 1'b0 || bus.req_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got lru_q=%b stall=%b req_done=%b want 0000/0/0", bus.lru_q,
               bus.stall, bus.req_done);
    end
  endtask

  task automatic test_directed();
    do_access(2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);  // hit way1, lru stays 0
    do_access(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);  // clean miss, 3 cycles
    do_access(2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);  // hit way0 -> lru[3]=1
    do_access(2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2, 2);  // dirty way1, 8 cycles
    do_access(2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);  // lru[0]=1
    do_access(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1);  // empty way0, no WB
  endtask

  task automatic test_err_and_idle_ready();
    do_access(2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0);  // both hit: err, way0
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_idle_rand();
      bus.mem_ready = (i == 0);
      #1;
      n_cmp++;
      if ({bus.req_done, bus.stall, bus.mem_rd, bus.mem_wr, bus.fill_we} !== 5'b0
          || bus.lru_q !== lru_m) begin
        n_bad++;
        $display("FAIL idle_mem_ready cycle=%0d: got rd=%b wr=%b lru=%b want 0/0/%b", i,
                 bus.mem_rd, bus.mem_wr, bus.lru_q, lru_m);
      end
    end
  endtask

  task automatic test_reset_in_fill();
    @(negedge clk);
    drive_idle_rand();
    bus.req_valid = 1'b1; bus.req_index = 2'd2; bus.hit0 = 1'b0; bus.hit1 = 1'b0;
    bus.valid0 = 1'b0;
    @(negedge clk);  // now in FILL
    rst = 1'b1; bus.mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.fill_we !== 1'b0 || bus.req_done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_in_fill: got fill_we=%b req_done=%b want 0/0", bus.fill_we,
               bus.req_done);
    end
    lru_m = 4'b0000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive_idle_rand();
      bus.mem_ready = 1'b1;
      #1;
      n_cmp++;
      if ({bus.req_done, bus.stall, bus.mem_rd, bus.mem_wr, bus.fill_we} !== 5'b0
          || bus.lru_q !== 4'b0000) begin
        n_bad++;
        $display("FAIL after_rst_in_fill cycle=%0d: got done=%b stall=%b rd=%b lru=%b", i,
                 bus.req_done, bus.stall, bus.mem_rd, bus.lru_q);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      do_access(2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    drive_idle_rand();
    test_reset();
    test_directed();
    test_err_and_idle_ready();
    test_directed();
    test_reset_in_fill();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
